// File: rtl/ex_operand_stage_pkg.sv
// Shared execute-stage definitions: datapath width and shifter function codes.
package ex_operand_stage_pkg;

  localparam int XLEN = 32;

  // Shifter function select driven towards the ALU; 2'b10 is unused.
  typedef enum logic [1:0] {
    ALUFN_SLL = 2'b00,
    ALUFN_SRL = 2'b01,
    ALUFN_SRA = 2'b11
  } alufn_e;

  // Map decode fields onto the shifter function select.
  function automatic alufn_e alufn_decode(input logic [2:0] funct3, input logic funct7_5);
    alufn_e sel;
    case ({funct7_5 & funct3[2], funct3[2]})
      2'b00:   sel = ALUFN_SLL;
      2'b01:   sel = ALUFN_SRL;
      2'b11:   sel = ALUFN_SRA;
      default: sel = ALUFN_SLL;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Per-operand bypass selection: EX/MEM beats MEM/WB beats the register file.
// x0 always reads as zero and is never a bypass target.
module fwd_mux
  import ex_operand_stage_pkg::*;
#(
  parameter int XLEN = ex_operand_stage_pkg::XLEN
) (
  input  logic [4:0]      addr,
  input  logic [XLEN-1:0] rf_data,
  input  logic            exmem_we,
  input  logic [4:0]      exmem_rd,
  input  logic [XLEN-1:0] exmem_data,
  input  logic            memwb_we,
  input  logic [4:0]      memwb_rd,
  input  logic [XLEN-1:0] memwb_data,
  output logic [XLEN-1:0] data
);

  logic addr_zero;
  logic hit_exmem;
  logic hit_memwb;

  assign addr_zero = (addr == 5'd0);
  assign hit_exmem = exmem_we && (exmem_rd == addr) && (exmem_rd != 5'd0);
  assign hit_memwb = memwb_we && (memwb_rd == addr) && (memwb_rd != 5'd0);

  // Priority select of the freshest producer for this source register.
  always_comb begin
    data = rf_data;
    if (addr_zero) begin
      data = '0;
    end else if (hit_exmem) begin
      data = exmem_data;
    end else if (hit_memwb) begin
      data = memwb_data;
    end else begin
      data = rf_data;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// Execute operand stage: resolves bypasses at capture and holds ALU/shifter
// operands in a single pipeline register with stall, flush and stall metrics.
module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter int XLEN  = ex_operand_stage_pkg::XLEN,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  input  logic [4:0]       rd_addr,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  imm,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             use_imm,
  input  logic             is_shift,
  input  logic             exmem_we,
  input  logic [4:0]       exmem_rd,
  input  logic [XLEN-1:0]  exmem_data,
  input  logic             memwb_we,
  input  logic [4:0]       memwb_rd,
  input  logic [XLEN-1:0]  memwb_data,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_a,
  output logic [XLEN-1:0]  out_b,
  output logic [4:0]       out_shamt,
  output logic [1:0]       out_alufn,
  output logic [4:0]       out_rd,
  output logic             out_is_shift,
  output logic [CNT_W-1:0] stall_cycles
);

  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic [XLEN-1:0] b_next;
  logic            capture;
  logic            count_en;

  assign in_ready = !stall;
  assign capture  = in_valid && in_ready;
  assign count_en = stall && out_valid;

  fwd_mux #(.XLEN(XLEN)) u_fwd_rs1 (
    .addr       (rs1_addr),
    .rf_data    (rs1_data),
    .exmem_we   (exmem_we),
    .exmem_rd   (exmem_rd),
    .exmem_data (exmem_data),
    .memwb_we   (memwb_we),
    .memwb_rd   (memwb_rd),
    .memwb_data (memwb_data),
    .data       (fwd_rs1)
  );

  fwd_mux #(.XLEN(XLEN)) u_fwd_rs2 (
    .addr       (rs2_addr),
    .rf_data    (rs2_data),
    .exmem_we   (exmem_we),
    .exmem_rd   (exmem_rd),
    .exmem_data (exmem_data),
    .memwb_we   (memwb_we),
    .memwb_rd   (memwb_rd),
    .memwb_data (memwb_data),
    .data       (fwd_rs2)
  );

  // Second operand: immediate for I-type, bypassed rs2 otherwise.
  always_comb begin
    b_next = fwd_rs2;
    if (use_imm) begin
      b_next = imm;
    end else begin
      b_next = fwd_rs2;
    end
  end

  // Pipeline register: flush empties, stall holds, otherwise capture or bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_a        <= '0;
      out_b        <= '0;
      out_shamt    <= 5'd0;
      out_alufn    <= 2'b00;
      out_rd       <= 5'd0;
      out_is_shift <= 1'b0;
    end else if (flush) begin
      out_valid    <= 1'b0;
    end else if (stall) begin
      out_valid    <= out_valid;
    end else if (capture) begin
      out_valid    <= 1'b1;
      out_a        <= fwd_rs1;
      out_b        <= b_next;
      out_shamt    <= b_next[4:0];
      out_alufn    <= alufn_decode(funct3, funct7_5);
      out_rd       <= rd_addr;
      out_is_shift <= is_shift;
    end else begin
      out_valid    <= 1'b0;
    end
  end

  // Saturating count of cycles spent holding a valid instruction under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (count_en && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cycles <= stall_cycles;
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage (counter width 4 to reach saturation).
module tb_ex_operand_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       rs1_addr, rs2_addr, rd_addr;
  logic [XLEN-1:0]  rs1_data, rs2_data, imm;
  logic [2:0]       funct3;
  logic             funct7_5, use_imm, is_shift;
  logic             exmem_we;
  logic [4:0]       exmem_rd;
  logic [XLEN-1:0]  exmem_data;
  logic             memwb_we;
  logic [4:0]       memwb_rd;
  logic [XLEN-1:0]  memwb_data;
  logic             stall, flush;
  logic             out_valid;
  logic [XLEN-1:0]  out_a, out_b;
  logic [4:0]       out_shamt;
  logic [1:0]       out_alufn;
  logic [4:0]       out_rd;
  logic             out_is_shift;
  logic [CNT_W-1:0] stall_cycles;

  int tests_run;
  int tests_failed;

  ex_operand_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .funct3(funct3), .funct7_5(funct7_5), .use_imm(use_imm), .is_shift(is_shift),
    .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_a(out_a), .out_b(out_b), .out_shamt(out_shamt),
    .out_alufn(out_alufn), .out_rd(out_rd), .out_is_shift(out_is_shift),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0; rd_addr = 5'd0;
    rs1_data = 32'd0; rs2_data = 32'd0; imm = 32'd0;
    funct3 = 3'b000; funct7_5 = 1'b0; use_imm = 1'b0; is_shift = 1'b0;
    exmem_we = 1'b0; exmem_rd = 5'd0; exmem_data = 32'd0;
    memwb_we = 1'b0; memwb_rd = 5'd0; memwb_data = 32'd0;
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    in_valid = 1'b1; rs1_addr = 5'd1; rs1_data = 32'h1111_1111;
    rst_n = 1'b0;
    tick(); tick();
    tests_run++;
    if ({out_valid, out_a, out_b, out_shamt, out_alufn, out_rd, out_is_shift, stall_cycles} !== '0) begin
      tests_failed++;
      $display("FAIL reset_state: valid=%0b a=%h b=%h cnt=%0d, required all zero", out_valid, out_a, out_b, stall_cycles);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL in_ready_idle: got %0b required 1", in_ready); end
    // Release between edges: no capture before the next rising edge.
    #2 rst_n = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL early_capture: valid=%0b required 0", out_valid); end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_a !== 32'h1111_1111) begin
      tests_failed++; $display("FAIL first_capture: valid=%0b a=%h required 1 11111111", out_valid, out_a);
    end
  endtask

  task automatic test_srai();
    clear_inputs();
    in_valid = 1'b1; rs1_addr = 5'd5; rs1_data = 32'h8000_0000; imm = 32'd4;
    funct7_5 = 1'b1; funct3 = 3'b101; use_imm = 1'b1; is_shift = 1'b1; rd_addr = 5'd7;
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_a !== 32'h8000_0000 || out_b !== 32'd4 || out_shamt !== 5'd4 ||
        out_alufn !== 2'b11 || out_rd !== 5'd7 || out_is_shift !== 1'b1) begin
      tests_failed++;
      $display("FAIL srai: v=%0b a=%h b=%h sh=%0d fn=%b rd=%0d is=%0b required 1 80000000 4 4 11 7 1",
               out_valid, out_a, out_b, out_shamt, out_alufn, out_rd, out_is_shift);
    end
  endtask

  task automatic test_shift_rtype();
    clear_inputs();
    in_valid = 1'b1; rs2_addr = 5'd9; rs2_data = 32'hFFFF_FFE3;
    funct3 = 3'b001; funct7_5 = 1'b1; is_shift = 1'b1;
    tick();
    tests_run++;
    if (out_shamt !== 5'd3 || out_alufn !== 2'b00 || out_b !== 32'hFFFF_FFE3) begin
      tests_failed++; $display("FAIL sll_rtype: sh=%0d fn=%b b=%h required 3 00 ffffffe3", out_shamt, out_alufn, out_b);
    end
    funct3 = 3'b101; funct7_5 = 1'b0; rs2_data = 32'h0000_003F;
    tick();
    tests_run++;
    if (out_shamt !== 5'd31 || out_alufn !== 2'b01) begin
      tests_failed++; $display("FAIL srl_rtype: sh=%0d fn=%b required 31 01", out_shamt, out_alufn);
    end
    funct3 = 3'b001; funct7_5 = 1'b1; rs2_data = 32'd0;
    tick();
    tests_run++;
    if (out_alufn !== 2'b00) begin
      tests_failed++; $display("FAIL no_fn10: fn=%b required 00", out_alufn);
    end
  endtask

  task automatic test_forwarding();
    clear_inputs();
    in_valid = 1'b1; rs1_addr = 5'd3; rs1_data = 32'h0000_0001;
    exmem_we = 1'b1; exmem_rd = 5'd3; exmem_data = 32'h0000_AAAA;
    memwb_we = 1'b1; memwb_rd = 5'd3; memwb_data = 32'h0000_5555;
    tick();
    tests_run++;
    if (out_a !== 32'h0000_AAAA) begin tests_failed++; $display("FAIL double_hazard: a=%h required 0000aaaa", out_a); end
    exmem_rd = 5'd4; rs2_addr = 5'd3; rs2_data = 32'h0000_0002;
    tick();
    tests_run++;
    if (out_a !== 32'h0000_5555 || out_b !== 32'h0000_5555) begin
      tests_failed++; $display("FAIL memwb_fwd: a=%h b=%h required 00005555 00005555", out_a, out_b);
    end
    exmem_we = 1'b0; memwb_we = 1'b0;
    tick();
    tests_run++;
    if (out_a !== 32'h0000_0001 || out_b !== 32'h0000_0002) begin
      tests_failed++; $display("FAIL rf_data: a=%h b=%h required 00000001 00000002", out_a, out_b);
    end
    rs1_addr = 5'd0; rs1_data = 32'hDEAD_BEEF;
    exmem_we = 1'b1; exmem_rd = 5'd0; exmem_data = 32'h0000_1234;
    memwb_we = 1'b1; memwb_rd = 5'd0;
    tick();
    tests_run++;
    if (out_a !== 32'd0) begin tests_failed++; $display("FAIL x0_source: a=%h required 00000000", out_a); end
  endtask

  task automatic test_bubble_flush();
    clear_inputs();
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL bubble: valid=%0b required 0", out_valid); end
    in_valid = 1'b1; flush = 1'b1; rs1_addr = 5'd2; rs1_data = 32'h0000_0042;
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_over_capture: valid=%0b required 0", out_valid); end
  endtask

  task automatic test_stall_flush();
    do_reset();
    in_valid = 1'b1; rs1_addr = 5'd6; rs1_data = 32'hCAFE_0006; rd_addr = 5'd6;
    tick();
    rs1_data = 32'h1234_5678; rd_addr = 5'd12; stall = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL in_ready_stall: got %0b required 0", in_ready); end
    tick(); tick(); tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_a !== 32'hCAFE_0006 || out_rd !== 5'd6 || stall_cycles !== 4'd3) begin
      tests_failed++;
      $display("FAIL stall_hold: v=%0b a=%h rd=%0d cnt=%0d required 1 cafe0006 6 3", out_valid, out_a, out_rd, stall_cycles);
    end
    flush = 1'b1;
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_in_stall: valid=%0b required 0", out_valid); end
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL stays_empty: valid=%0b required 0", out_valid); end
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 1'b1; rs1_addr = 5'd8; rs1_data = 32'h0000_0808;
    tick();
    stall = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || stall_cycles !== 4'd0 || out_a !== 32'd0) begin
      tests_failed++; $display("FAIL async_reset: v=%0b cnt=%0d a=%h required 0 0 0", out_valid, stall_cycles, out_a);
    end
    tick();
    rst_n = 1'b1;
    stall = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    in_valid = 1'b1; rs1_addr = 5'd10; rs1_data = 32'h0000_0A0A;
    tick();
    stall = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    tests_run++;
    if (stall_cycles !== 4'd15 || out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL saturation: cnt=%0d v=%0b required 15 1", stall_cycles, out_valid);
    end
    stall = 1'b0;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_srai();
    test_shift_rtype();
    test_forwarding();
    test_bubble_flush();
    test_stall_flush();
    test_async_reset();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
REQ-001 Parameter: XLEN, 32, datapath width.
REQ-002 Parameter: CNT_W, 16, width of the stall-cycle counter.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 Port: clk  in  1  clock; all state updates on the rising edge.
REQ-005 Port: rst_n  in  1  asynchronous active-low reset.
REQ-006 Port: in_valid  in  1  decode presents an instruction.
REQ-007 Port: in_ready  out  1  stage can accept an instruction this cycle.
REQ-008 Port: rs1_addr, rs2_addr, rd_addr  in  5 each  register indices.
REQ-009 Port: rs1_data, rs2_data, imm  in  XLEN each  register-file reads and immediate.
REQ-010 Port: funct3  in  3; funct7_5  in  1; use_imm  in  1; is_shift  in  1  decode fields.
REQ-011 Port: exmem_we  in  1; exmem_rd  in  5; exmem_data  in  XLEN  EX/MEM forward source.
REQ-012 Port: memwb_we  in  1; memwb_rd  in  5; memwb_data  in  XLEN  MEM/WB forward source.
REQ-013 Port: stall  in  1  shared memory port busy; hold the stage.
REQ-014 Port: flush  in  1  discard the held instruction (branch or trap).
REQ-015 Port: out_valid  out  1  execute operands valid.
REQ-016 Port: out_a, out_b  out  XLEN each  ALU operands; out_a feeds the shifter data input.
REQ-017 Port: out_shamt  out  5; out_alufn  out  2; out_rd  out  5; out_is_shift  out  1.
REQ-018 Port: stall_cycles  out  CNT_W  saturating count of cycles with stall=1 and out_valid=1.

Function
REQ-019 in_ready SHALL equal !stall.
REQ-020 The stage SHALL capture inputs on a clock edge where in_valid && in_ready; out_valid becomes 1 on the next cycle, giving 1-cycle latency.
REQ-021 When in_ready=1 and in_valid=0, out_valid SHALL become 0 at the edge; the payload need not change.
REQ-022 When stall=1, all output registers SHALL hold their values.
REQ-023 Flush: flush=1 SHALL clear out_valid at the edge, has priority over stall and capture, and leaves the stage empty.
REQ-024 Forwarding: resolved per source operand at capture; EX/MEM match (we=1, rd==addr, rd!=0) first, then MEM/WB match, else register-file data.
REQ-025 Index 0 SHALL never be forwarded; operands read from x0 are captured as 0 regardless of the rs*_data value.
REQ-026 out_a = forwarded rs1; out_b = use_imm ? imm : forwarded rs2.
REQ-027 out_shamt = out_b[4:0], so I-type uses imm[4:0] and R-type uses rs2[4:0]; upper bits are ignored.
REQ-028 out_alufn = {funct7_5 & funct3[2], funct3[2]}: SLL=00, SRL=01, SRA=11; encoding 10 SHALL never be produced.
REQ-029 stall_cycles SHALL increment once per cycle with stall && out_valid, saturate at all-ones, and never wrap.

Reset
REQ-030 Asserting rst_n=0 SHALL immediately force out_valid=0, out_a=out_b=0, out_shamt=0, out_alufn=0, out_rd=0, out_is_shift=0 and stall_cycles=0, including mid-stall.
REQ-031 The first capture after rst_n deasserts SHALL occur no earlier than the first rising edge at which rst_n is already 1.

Structure
REQ-032 XLEN and the ALUFN shift encodings (SLL/SRL/SRA) SHALL live in the shared defines package used by the execute stage.
REQ-033 Forwarding selection SHALL be one sub-module, fwd_mux, instantiated twice (rs1 and rs2).

Verification
REQ-034 SRAI: rs1=x5 holds 0x80000000, imm=4, funct7_5=1, funct3=101 -> next cycle out_a=0x80000000, out_shamt=4, out_alufn=11.
REQ-035 Double hazard: exmem_rd=memwb_rd=3 with exmem_data=0xAAAA and memwb_data=0x5555, rs1=x3 -> out_a=0xAAAA.
REQ-036 x0 source: rs1_addr=0, exmem_rd=0, exmem_we=1, exmem_data=0x1234 -> out_a=0.
REQ-037 Stall then flush: stall for 3 cycles with out_valid=1 -> outputs constant, stall_cycles=3; flush with stall=1 -> out_valid=0 next cycle.
REQ-038 Async reset: drop rst_n between edges while stalled -> out_valid=0 and stall_cycles=0 before the next edge.
REQ-039 Saturation: with CNT_W=4, hold stall for 20 cycles -> stall_cycles=15.
